// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO drain: packs BYTES consecutive DW-bit entries into one word on a valid/ready stream.
// A flush request drains in-flight reads and emits any partial word tagged last.
module fifo_rd_packer #(
    parameter int DW    = 8,
    parameter int BYTES = 4,
    localparam int OW   = DW * BYTES,
    localparam int CW   = $clog2(BYTES) + 1
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          empty,
    output logic          rinc,
    input  logic [DW-1:0] rdata,
    input  logic          flush,
    output logic [OW-1:0] out_data,
    output logic [CW-1:0] out_bytes,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          flush_done
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;

    localparam logic [CW-1:0] FULL = CW'(BYTES);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          rd_pend;
    logic [OW-1:0] pack;
    logic [CW:0]   inflight;
    logic          out_free;
    logic          word_xfer;

    // Reads are only issued while packed plus outstanding entries leave a free slot.
    always_comb begin
        inflight  = {1'b0, cnt} + {{CW{1'b0}}, rd_pend};
        rinc      = rrst && !empty && (state == RUN) && (inflight < {1'b0, FULL});
        out_free  = !out_valid || out_ready;
        word_xfer = (cnt == FULL) && out_free;
    end

    always_ff @(posedge rclk) begin
        if (!rrst) begin
            state      <= RUN;
            cnt        <= '0;
            rd_pend    <= 1'b0;
            pack       <= '0;
            out_data   <= '0;
            out_bytes  <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            rd_pend    <= rinc;

            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (rd_pend) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (cnt == CW'(i))
                        pack[i*DW +: DW] <= rdata;
                end
                cnt <= cnt + CW'(1);
            end

            if (word_xfer) begin
                out_data  <= pack;
                out_bytes <= FULL;
                out_last  <= 1'b0;
                out_valid <= 1'b1;
                cnt       <= '0;
                pack      <= '0;
            end

            case (state)
                RUN: begin
                    if (flush)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!rd_pend && (cnt < FULL))
                        state <= EMIT;
                end
                EMIT: begin
                    if (cnt == '0) begin
                        flush_done <= 1'b1;
                        state      <= RUN;
                    end else if (out_free) begin
                        // pack is zeroed after every word, so unused upper slots read as zero
                        out_data   <= pack;
                        out_bytes  <= cnt;
                        out_last   <= 1'b1;
                        out_valid  <= 1'b1;
                        cnt        <= '0;
                        pack       <= '0;
                        flush_done <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue models the FIFO read port (one-cycle rdata latency).
module tb_fifo_rd_packer;

    logic        rclk;
    logic        rrst;
    logic        empty;
    logic        rinc;
    logic [7:0]  rdata;
    logic        flush;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        flush_done;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int ov_cnt = 0;
    int fd0;
    int ov0;

    logic [7:0] fq[$];

    fifo_rd_packer #(.DW(8), .BYTES(4)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .empty      (empty),
        .rinc       (rinc),
        .rdata      (rdata),
        .flush      (flush),
        .out_data   (out_data),
        .out_bytes  (out_bytes),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush_done (flush_done)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO read-port model: data appears the cycle after an accepted rinc
    always @(posedge rclk) begin
        if (rinc && !empty) begin
            rdata <= fq.pop_front();
            if (fq.size() == 0)
                empty <= 1'b1;
        end
    end

    always @(posedge rclk) begin
        if (flush_done) fd_cnt++;
        if (out_valid)  ov_cnt++;
    end

    task automatic tick();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        empty = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_flush_done(input string tag);
        int n;
        n = 0;
        while (!flush_done && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 64'(flush_done), 64'd1);
    endtask

    initial begin
        rrst      = 1'b0;
        empty     = 1'b1;
        rdata     = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(negedge rclk);

        // 1: reset with data available
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick(); tick(); tick();
        check("rst_rinc", 64'(rinc), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_bytes", 64'(out_bytes), 64'd0);
        check("rst_fdone", 64'(flush_done), 64'd0);
        ov0 = ov_cnt;
        rrst = 1'b1;
        tick();
        check("rel_rinc", 64'(rinc), 64'd1);

        // 2: single word
        wait_valid("w1");
        check("w1_data", 64'(out_data), 64'h44332211);
        check("w1_bytes", 64'(out_bytes), 64'd4);
        check("w1_last", 64'(out_last), 64'd0);
        tick();
        check("w1_drop", 64'(out_valid), 64'd0);
        tick(); tick();
        check("w1_beats", 64'(ov_cnt - ov0), 64'd1);

        // 3: backpressure
        out_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        wait_valid("w2");
        check("w2_data", 64'(out_data), 64'h44332211);
        for (int i = 0; i < 10; i++) tick();
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'h44332211);
        check("hold_bytes", 64'(out_bytes), 64'd4);
        check("hold_rinc", 64'(rinc), 64'd0);
        check("hold_cnt", 64'(dut.cnt), 64'd4);
        out_ready = 1'b1;
        tick();
        check("w3_valid", 64'(out_valid), 64'd1);
        check("w3_data", 64'(out_data), 64'h88776655);
        check("w3_last", 64'(out_last), 64'd0);
        tick();
        check("w3_drop", 64'(out_valid), 64'd0);

        // 4: flush of a partial word
        push(8'hAA); push(8'hBB); push(8'hCC);
        for (int i = 0; i < 8; i++) tick();
        check("p_cnt", 64'(dut.cnt), 64'd3);
        check("p_novalid", 64'(out_valid), 64'd0);
        fd0 = fd_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_flush_done("fl1");
        check("fl1_valid", 64'(out_valid), 64'd1);
        check("fl1_data", 64'(out_data), 64'h00CCBBAA);
        check("fl1_bytes", 64'(out_bytes), 64'd3);
        check("fl1_last", 64'(out_last), 64'd1);
        tick();
        check("fl1_fd_low", 64'(flush_done), 64'd0);
        check("fl1_drop", 64'(out_valid), 64'd0);
        tick(); tick();
        check("fl1_fd_pulses", 64'(fd_cnt - fd0), 64'd1);

        // 5: empty flush, second flush during DRAIN ignored
        fd0 = fd_cnt;
        ov0 = ov_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("fl2_fd_pulses", 64'(fd_cnt - fd0), 64'd1);
        check("fl2_no_valid", 64'(ov_cnt - ov0), 64'd0);
        check("fl2_state_run", 64'(dut.state), 64'd0);

        // 6: reset discards a partially packed word
        push(8'h01); push(8'h02);
        for (int i = 0; i < 6; i++) tick();
        check("r6_cnt_pre", 64'(dut.cnt), 64'd2);
        rrst = 1'b0;
        tick();
        check("r6_valid", 64'(out_valid), 64'd0);
        check("r6_cnt", 64'(dut.cnt), 64'd0);
        check("r6_rinc", 64'(rinc), 64'd0);
        rrst = 1'b1;
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        wait_valid("w4");
        check("w4_data", 64'(out_data), 64'h40302010);
        check("w4_bytes", 64'(out_bytes), 64'd4);
        check("w4_last", 64'(out_last), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
